// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the encoder/decoder pair. Constants are active-high
// with bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Raw (active-low) bus with every segment dark.
    localparam logic [6:0] SEG_BLANK_RAW = 7'b111_1111;

    // Literals read g..a left to right.
    localparam logic [6:0] CODE_0  = 7'b000_0000;
    localparam logic [6:0] CODE_1  = 7'b000_0110;
    localparam logic [6:0] CODE_2  = 7'b101_1011;
    localparam logic [6:0] CODE_3  = 7'b100_1111;
    localparam logic [6:0] CODE_4  = 7'b110_0110;
    localparam logic [6:0] CODE_5  = 7'b110_1101;
    localparam logic [6:0] CODE_6  = 7'b111_1101;
    localparam logic [6:0] CODE_7  = 7'b000_0111;
    localparam logic [6:0] CODE_8  = 7'b111_1111;
    localparam logic [6:0] CODE_9  = 7'b110_1111;
    localparam logic [6:0] CODE_10 = 7'b011_1111;
    localparam logic [6:0] CODE_11 = CODE_3;

    // Returns {in_code_set, value}; the shared 3/11 pattern always yields 3.
    function automatic logic [4:0] seg7_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            CODE_0:  r = {1'b1, 4'd0};
            CODE_1:  r = {1'b1, 4'd1};
            CODE_2:  r = {1'b1, 4'd2};
            CODE_3:  r = {1'b1, 4'd3};
            CODE_4:  r = {1'b1, 4'd4};
            CODE_5:  r = {1'b1, 4'd5};
            CODE_6:  r = {1'b1, 4'd6};
            CODE_7:  r = {1'b1, 4'd7};
            CODE_8:  r = {1'b1, 4'd8};
            CODE_9:  r = {1'b1, 4'd9};
            CODE_10: r = {1'b1, 4'd10};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_stab_filter.sv
// Stability filter: a sample must repeat STABLE_CYCLES times in a row before it is
// considered settled. hit marks the edge on which the count reaches the threshold.
module seg7_stab_filter #(
    parameter int               WIDTH         = 7,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL       = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cand,
    output logic             hit,
    output logic             stable
);

    localparam logic [3:0] SC = 4'(STABLE_CYCLES);

    logic [3:0] cnt;
    logic       same;

    assign same = (din == cand);
    assign hit  = same && (cnt == SC - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= RST_VAL;
            cnt    <= 4'd0;
            stable <= 1'b0;
        end else if (!same) begin
            cand   <= din;
            cnt    <= 4'd1;
            stable <= 1'b0;
        end else begin
            if (cnt < SC) cnt <= cnt + 4'd1;
            if (hit)      stable <= 1'b1;
        end
    end

endmodule

// File: rtl/seg7_decoder.sv
// Active-low 7-segment receiver: filters transients, decodes each newly stable pattern.
// Define SEG7_DEC_SYNC_EN to put a 2-flop synchroniser in front of the filter.
import seg7_pkg::*;

module seg7_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] bin,
    output logic       valid,
    output logic       err,
    output logic       stable
);

    logic [6:0] samp;

`ifdef SEG7_DEC_SYNC_EN
    logic [6:0] sync1, sync2;

    // Reset to blank so a dark bus after reset looks like no change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SEG_BLANK_RAW;
            sync2 <= SEG_BLANK_RAW;
        end else begin
            sync1 <= seg;
            sync2 <= sync1;
        end
    end
    assign samp = sync2;
`else
    assign samp = seg;
`endif

    logic [6:0] cand, last;
    logic       hit, commit;
    logic [4:0] dec;

    seg7_stab_filter #(
        .WIDTH        (7),
        .STABLE_CYCLES(STABLE_CYCLES),
        .RST_VAL      (SEG_BLANK_RAW)
    ) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (samp),
        .cand  (cand),
        .hit   (hit),
        .stable(stable)
    );

    // Re-settling on the pattern already shown is silent.
    assign commit = hit && (cand != last);
    assign dec    = seg7_decode(~cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last  <= SEG_BLANK_RAW;
            bin   <= 4'd0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= commit;
            if (commit) begin
                last <= cand;
                if (dec[4]) begin
                    bin <= dec[3:0];
                    err <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder; patterns are written in a..g order (a leftmost).
// Works with or without SEG7_DEC_SYNC_EN.
module tb_seg7_decoder;

    localparam int S = 4;
`ifdef SEG7_DEC_SYNC_EN
    localparam int LAT = S + 2;
`else
    localparam int LAT = S;
`endif

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] bin;
    logic       valid;
    logic       err;
    logic       stable;

    int   tests_run;
    int   tests_failed;
    int   pulses;
    int   first_pulse;
    logic saw_low;
    logic low_a;

    logic [6:0] pat [12];
    int         exp_bin [12];

    seg7_decoder #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (seg),
        .bin   (bin),
        .valid (valid),
        .err   (err),
        .stable(stable)
    );

    always #5 clk = ~clk;

    // Spec-order active-high pattern (a is MSB) to raw active-low bus (a on bit 0).
    function automatic logic [6:0] raw(input logic [6:0] s);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = ~s[6-i];
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] s, input int n);
        seg         = raw(s);
        pulses      = 0;
        first_pulse = 0;
        saw_low     = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
            if (!stable) saw_low = 1'b1;
        end
    endtask

    initial begin
        pat = '{7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1111110, 7'b1111001};
        exp_bin = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 3};
        tests_run    = 0;
        tests_failed = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        seg   = 7'h7f;
        #12;
        chk("rst_bin", bin, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_stable", stable, 0);

        @(negedge clk);
        rst_n = 1'b1;
        hold(7'b0000000, 8);
        chk("blank_nopulse", pulses, 0);

        // Scenario 1: digit 1 held
        hold(7'b0110000, 8);
        chk("s1_pulses", pulses, 1);
        chk("s1_latency", first_pulse, LAT);
        chk("s1_bin", bin, 1);
        chk("s1_err", err, 0);
        chk("s1_stable", stable, 1);

        // Scenario 2: 2-cycle glitch to digit 2, then back to 1
        hold(7'b1101101, 2);
        low_a = saw_low;
        chk("s2_glitch_nopulse", pulses, 0);
        hold(7'b0110000, 8);
        chk("s2_return_nopulse", pulses, 0);
        chk("s2_bin", bin, 1);
        chk("s2_stable_drop", int'(low_a | saw_low), 1);
        chk("s2_stable_back", stable, 1);

        // Scenario 3: pattern outside the code set, then 9
        hold(7'b0000001, 8);
        chk("s3_bad_pulses", pulses, 1);
        chk("s3_bad_err", err, 1);
        chk("s3_bad_binhold", bin, 1);
        hold(7'b1111011, 8);
        chk("s3_nine_pulses", pulses, 1);
        chk("s3_nine_bin", bin, 9);
        chk("s3_nine_err", err, 0);

        // Scenario 4: encoder sequence 0..11
        for (int i = 0; i < 12; i++) begin
            hold(pat[i], 8);
            chk($sformatf("seq%0d_pulses", i), pulses, 1);
            chk($sformatf("seq%0d_latency", i), first_pulse, LAT);
            chk($sformatf("seq%0d_bin", i), bin, exp_bin[i]);
            chk($sformatf("seq%0d_err", i), err, 0);
        end

        // Scenario 5: reset mid-count
        hold(7'b1011011, 2);
        #2;
        rst_n = 1'b0;
        seg   = raw(7'b0000000);
        #1;
        chk("s5_async_bin", bin, 0);
        chk("s5_async_valid", valid, 0);
        chk("s5_async_err", err, 0);
        chk("s5_async_stable", stable, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold(7'b0000000, 8);
        chk("s5_blank_nopulse", pulses, 0);
        chk("s5_blank_bin", bin, 0);
        hold(7'b1011011, 8);
        chk("s5_five_pulses", pulses, 1);
        chk("s5_five_latency", first_pulse, LAT);
        chk("s5_five_bin", bin, 5);

        // Glitch of S-1 samples never commits
        hold(7'b1101101, S - 1);
        chk("g_glitch_nopulse", pulses, 0);
        hold(7'b1011011, 8);
        chk("g_after_nopulse", pulses, 0);
        chk("g_bin", bin, 5);
        chk("g_stable", stable, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
# seg7_decoder

Receive-side counterpart of the team's binary-to-7-segment encoder. The block samples an active-low 7-segment bus (segment order a..g on bits 0..6), typically driven by another board or by the encoder in a loopback, and filters out transient patterns. It decodes each newly stable pattern back to a 4-bit value and flags patterns outside the code set. It sits at the input side of the dice-launcher display path, in test harnesses, and in board-to-board links.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is committed; legal range 2..15.
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- SegIn  in  [0:6]  active-low segment lines; bit 0 = a … bit 6 = g.
- BinOut  out  [3:0]  last valid decoded value.
- ValidOut  out  1  one-cycle pulse on each commit of a new pattern.
- ErrOut  out  1  level, high while the last committed pattern is outside the code set.
- StableOut  out  1  level, high while the filter count has reached STABLE_CYCLES.

## Operation
- The effective sample E is SegIn, or the synchronised SegIn when SEG7_DEC_SYNC_EN is defined. The decoder works on P = ~E (active-high).
- Filter registers:
  - Cand [0:6]: candidate raw pattern.
  - Cnt: 4 bits, saturating at STABLE_CYCLES.
  - Last [0:6]: last committed raw pattern.
- Filter rules, per edge:
  - E != Cand: Cand <= E, Cnt <= 1.
  - E == Cand and Cnt < STABLE_CYCLES: Cnt <= Cnt+1.
  - Otherwise Cnt holds.
- Commit event: the edge where E == Cand, Cnt == STABLE_CYCLES-1 and Cand != Last.
  - Last <= Cand and ValidOut <= 1 for exactly one cycle.
  - If P is in the code set: BinOut <= decoded value and ErrOut <= 0.
  - If P is not in the code set: ErrOut <= 1 and BinOut holds.
- If the stable pattern equals Last, Cnt still saturates, but there is no pulse and no output change.
- Code set (P, active-high a..g):
  - 0000000→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 1111110→10.
  - 11 shares pattern 1111001 with 3. That pattern always decodes to 3, and value 11 is never produced.
- A glitch shorter than STABLE_CYCLES samples restarts the count and never commits.
- Reset values (immediate on Rst_n low, independent of Clk):
  - Cand = Last = 7'b1111111 (blank), Cnt = 0.
  - BinOut = 0, ValidOut = 0, ErrOut = 0, StableOut = 0.
  - Synchroniser flops reset to 1 (blank).
- Reset mid-count discards the candidate. A blank bus after reset release produces no pulse.

## Timing
- Without the macro: if SegIn changes before edge k and then holds, Cand loads at k and the commit occurs at edge k+STABLE_CYCLES-1. ValidOut is high during the following cycle; BinOut and ErrOut update at that same edge.
- With the macro: add 2 edges of latency.
- Default (STABLE_CYCLES = 4, no sync): 4 edges from the first sampling edge to outputs valid.
- StableOut rises at the same edge as a commit would occur. It falls at the first edge where E != Cand.
- Back-to-back distinct stable patterns produce ValidOut pulses at least STABLE_CYCLES cycles apart.

## Configuration
- SEG7_DEC_SYNC_EN:
  - Defined: SegIn passes through a 2-flop synchroniser, reset to all-ones, before the filter. This is required when SegIn is asynchronous to Clk.
  - Undefined: SegIn feeds the filter directly (same-clock source), with 2 fewer edges of latency.

## Structure
- Shared package seg7_pkg:
  - 7-bit active-high code constants for values 0..11.
  - Segment bit-index constants a..g.
  - Blank-pattern constant.
  - The encoder should reuse the same constants.
- Sub-module seg7_stab_filter, parameterised by width and STABLE_CYCLES:
  - Contains Cand, Cnt, the stable flag and the commit strobe.
- The top level holds Last, the decode logic, the output registers and the optional synchroniser.

## Test plan
- Reset, then SegIn = ~0110000 held, no sync → BinOut=1 and ValidOut pulses once, 4 edges after the first sampling edge; ErrOut=0.
- Stable 1, then ~1101101 for 2 cycles, then back to ~0110000 → no ValidOut; BinOut stays 1; StableOut drops, then returns.
- Stable ~0000001 → ValidOut pulse, ErrOut=1, BinOut holds; then ~1111011 stable → BinOut=9, ErrOut=0, one pulse.
- Encoder in loopback driven with 0..11 in sequence, each held 8 cycles → BinOut follows 0..10, then 3 for input 11. The transition 10→11 gives one pulse; the 3-pattern repeat after 2 gives a pulse, because Last differs.
- Rst_n pulled low at Cnt=2 → all outputs 0 asynchronously; after release with a blank bus, no pulse until ~1011011 has been stable 4 cycles → BinOut=5.
- With SEG7_DEC_SYNC_EN, repeat scenario 1 → ValidOut at first edge + 6; glitch of 3 cycles with STABLE_CYCLES=4 → no commit.
